// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell processes an operand
// bit pair per clock, LSB first, with a start/busy/done handshake.

module fulladd (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] a_sr, b_sr;
    logic             carry;
    // the bit that would sit at acc[0] is never read, so it is not stored
    logic [WIDTH-2:0] acc;
    logic [CW-1:0]    cnt;
    logic             fa_sum, fa_cout;
    logic [WIDTH-1:0] res_nxt;

    fulladd u_fa (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .cin  (carry),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    assign res_nxt = {fa_sum, acc};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (cnt == LAST) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr  <= '0;
            b_sr  <= '0;
            carry <= 1'b0;
            acc   <= '0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        a_sr  <= op_a;
                        b_sr  <= op_b;
                        carry <= cin;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    acc   <= res_nxt[WIDTH-1:1];
                    carry <= fa_cout;
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    cnt   <= cnt + 1'b1;
                    // final bit: publish the whole result at once
                    if (cnt == LAST) begin
                        sum  <= res_nxt;
                        cout <= fa_cout;
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: WIDTH=8 directed cases and an
// exhaustive WIDTH=2 sweep, against a cycle-count/arithmetic model.

module tb_serial_adder;
    logic       clk = 1'b0;
    logic       rst;

    logic       start8, c8;
    logic [7:0] a8, b8;
    logic       busy8, done8, cout8;
    logic [7:0] sum8;

    logic       start2, c2;
    logic [1:0] a2, b2;
    logic       busy2, done2, cout2;
    logic [1:0] sum2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst   (rst),
        .start (start8),
        .op_a  (a8),
        .op_b  (b8),
        .cin   (c8),
        .busy  (busy8),
        .done  (done8),
        .sum   (sum8),
        .cout  (cout8)
    );

    serial_adder #(.WIDTH(2)) dut2 (
        .clk   (clk),
        .rst   (rst),
        .start (start2),
        .op_a  (a2),
        .op_b  (b2),
        .cin   (c2),
        .busy  (busy2),
        .done  (done2),
        .sum   (sum2),
        .cout  (cout2)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // model: edges left until idle; result appears on the edge leaving 2
    int         m8_left;
    logic [8:0] m8_res;
    logic [7:0] m8_sum;
    logic       m8_cout;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m8_left <= 0;
            m8_sum  <= '0;
            m8_cout <= 1'b0;
        end else if (m8_left == 0) begin
            if (start8) begin
                m8_left <= 9;
                m8_res  <= a8 + b8 + c8;
            end
        end else begin
            if (m8_left == 2) {m8_cout, m8_sum} <= m8_res;
            m8_left <= m8_left - 1;
        end
    end

    int         m2_left;
    logic [2:0] m2_res;
    logic [1:0] m2_sum;
    logic       m2_cout;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m2_left <= 0;
            m2_sum  <= '0;
            m2_cout <= 1'b0;
        end else if (m2_left == 0) begin
            if (start2) begin
                m2_left <= 3;
                m2_res  <= a2 + b2 + c2;
            end
        end else begin
            if (m2_left == 2) {m2_cout, m2_sum} <= m2_res;
            m2_left <= m2_left - 1;
        end
    end

    always @(negedge clk) begin
        chk("busy8", busy8, m8_left != 0);
        chk("done8", done8, m8_left == 1);
        chk("sum8",  sum8,  m8_sum);
        chk("cout8", cout8, m8_cout);
        chk("busy2", busy2, m2_left != 0);
        chk("done2", done2, m2_left == 1);
        chk("sum2",  sum2,  m2_sum);
        chk("cout2", cout2, m2_cout);
    end

    task automatic run8(input logic [7:0] a, input logic [7:0] b,
                        input logic c, input logic [7:0] es,
                        input logic ec, input string nm);
        int n;
        int bc;
        @(negedge clk);
        start8 = 1'b1; a8 = a; b8 = b; c8 = c;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        a8 = 8'($urandom);
        b8 = 8'($urandom);
        n = 0;
        bc = 0;
        do begin
            @(negedge clk);
            n++;
            if (busy8) bc++;
        end while (!done8 && n < 40);
        chk({nm, "_lat"}, n, 9);
        chk({nm, "_sum"}, sum8, es);
        chk({nm, "_cout"}, cout8, ec);
        while (busy8 && n < 40) begin
            @(negedge clk);
            n++;
            if (busy8) bc++;
        end
        chk({nm, "_busy"}, bc, 9);
    endtask

    task automatic run2(input logic [1:0] a, input logic [1:0] b,
                        input logic c);
        int n;
        int bc;
        logic [2:0] e;
        e = a + b + c;
        @(negedge clk);
        start2 = 1'b1; a2 = a; b2 = b; c2 = c;
        @(posedge clk);
        #1;
        start2 = 1'b0;
        n = 0;
        bc = 0;
        do begin
            @(negedge clk);
            n++;
            if (busy2) bc++;
        end while (!done2 && n < 20);
        chk("w2_lat", n, 3);
        chk("w2_result", {cout2, sum2}, e);
        while (busy2 && n < 20) begin
            @(negedge clk);
            n++;
            if (busy2) bc++;
        end
        chk("w2_idle_edges", bc + 1, 4);
    endtask

    initial begin
        int dcnt;
        int pos[3];
        logic stable;

        rst = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0; c8 = 1'b0;
        start2 = 1'b0; a2 = '0; b2 = '0; c2 = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy8, 1'b0);
        chk("rst_done", done8, 1'b0);
        chk("rst_sum",  sum8,  8'h00);
        chk("rst_cout", cout8, 1'b0);
        #2 rst = 1'b0;

        run8(8'h3C, 8'h42, 1'b0, 8'h7E, 1'b0, "t3c42");
        run8(8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, "ta55a");
        run8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "tff01");

        // operands and start changed while running
        @(negedge clk);
        start8 = 1'b1; a8 = 8'h10; b8 = 8'h20; c8 = 1'b0;
        @(posedge clk);
        #1 start8 = 1'b0;
        repeat (3) @(negedge clk);
        start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        dcnt = 0;
        repeat (14) begin
            @(negedge clk);
            if (done8) dcnt++;
        end
        chk("midrun_dones", dcnt, 1);
        chk("midrun_sum", sum8, 8'h30);
        chk("midrun_cout", cout8, 1'b0);

        // start held for three back-to-back operations
        @(negedge clk);
        start8 = 1'b1; a8 = 8'h12; b8 = 8'h34; c8 = 1'b0;
        dcnt = 0;
        stable = 1'b1;
        for (int i = 0; i < 60 && dcnt < 3; i++) begin
            @(negedge clk);
            if (dcnt > 0 && sum8 !== 8'h46) stable = 1'b0;
            if (done8) begin
                pos[dcnt] = i;
                dcnt++;
            end
        end
        start8 = 1'b0;
        chk("held_pulses", dcnt, 3);
        chk("held_gap1", pos[1] - pos[0], 10);
        chk("held_gap2", pos[2] - pos[1], 10);
        chk("held_stable", stable, 1'b1);
        chk("held_sum", sum8, 8'h46);
        repeat (2) @(negedge clk);

        // asynchronous reset while bit 4 is being processed
        @(negedge clk);
        start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b0;
        @(posedge clk);
        #1 start8 = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", busy8, 1'b0);
        chk("arst_done", done8, 1'b0);
        chk("arst_sum",  sum8,  8'h00);
        chk("arst_cout", cout8, 1'b0);
        @(negedge clk);
        #2 rst = 1'b0;
        run8(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, "after_rst");

        for (int i = 0; i < 32; i++) begin
            run2(i[1:0], i[3:2], i[4]);
        end

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial WIDTH-bit adder that sits directly upstream of the `fulladd` cell and drives it. It instantiates one `fulladd`, feeds it one operand bit pair plus the registered carry per clock (LSB first), and captures its `sum`/`cout` back into a result shift register and carry flop. A start/busy/done handshake sequences each addition. It is the area-minimal alternative to a WIDTH-stage ripple chain.

## Interface
Parameters:
- `WIDTH`, default 8: operand and result width; legal range 2..32.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: reset, asynchronous, active-high.
- `start`, input, 1: request an addition; sampled only in IDLE.
- `op_a`, input, WIDTH: operand A, captured on the accepting edge.
- `op_b`, input, WIDTH: operand B, captured on the accepting edge.
- `cin`, input, 1: carry-in, captured on the accepting edge.
- `busy`, output, 1: high whenever the state is not IDLE.
- `done`, output, 1: one-cycle pulse; `sum`/`cout` are valid from this cycle.
- `sum`, output, WIDTH: registered result, held until the next result is written.
- `cout`, output, 1: registered carry-out, held with `sum`.

## Operation
- Internal state:
  - `a_sr`, `b_sr`: WIDTH-bit right-shift registers.
  - `carry`: 1-bit flop.
  - `acc`: WIDTH-bit shift register that accumulates result bits.
  - `cnt`: bit counter, $clog2(WIDTH) bits.
  - `state`: IDLE, RUN or DONE.
- The `fulladd` instance is driven with `a = a_sr[0]`, `b = b_sr[0]`, `cin = carry`.
- IDLE, with `start` = 1 at the edge:
  - Load `a_sr <= op_a`, `b_sr <= op_b`, `carry <= cin`, `cnt <= 0`.
  - Go to RUN.
- IDLE, with `start` = 0: no state change.
- Each RUN edge:
  - `acc <= {fa_sum, acc[WIDTH-1:1]}`.
  - `carry <= fa_cout`.
  - Shift `a_sr` and `b_sr` right by 1, zero-filling the MSB.
  - `cnt <= cnt + 1`.
- RUN edge with `cnt == WIDTH-1`: go to DONE, and write `sum <= {fa_sum, acc[WIDTH-1:1]}` and `cout <= fa_cout`. This is the final bit.
- DONE: `done` = 1 for exactly this cycle. The next edge always returns to IDLE.
- `start` is ignored in RUN and DONE; no queuing.
- Operand inputs are don't-care outside the accepting edge. Changing them mid-operation has no effect.
- Arithmetic: `{cout, sum} = op_a + op_b + cin`, computed modulo 2^(WIDTH+1). No overflow flag.
- `sum`/`cout` change only at the edge entering DONE. They are never partially updated.

## Timing
- Reset (asynchronous, takes effect immediately, independent of `clk`):
  - `state` = IDLE.
  - `busy` = 0, `done` = 0, `sum` = 0, `cout` = 0.
  - All internal registers = 0.
- Reset mid-operation: the operation is aborted and the previous result is lost (`sum`/`cout` = 0). After `rst` deasserts, the first edge with `start` = 1 starts a fresh operation.
- Latency, with edge E0 accepting `start`:
  - RUN occupies edges E1..E_WIDTH.
  - `done` is high in the cycle after E_WIDTH.
  - IDLE is re-entered at E_(WIDTH+1).
- `busy` goes high after E0 and low after E_(WIDTH+1).
- Throughput: with `start` held at 1, one addition is accepted every WIDTH+2 edges.
- `done` and `busy` are never both low while a result is pending. `done` is never high for more than one cycle.

## Test plan
- WIDTH=8, `op_a` = 0x3C, `op_b` = 0x42, `cin` = 0, 1-cycle `start` pulse -> `done` pulses exactly 9 edges after the accepting edge; `sum` = 0x7E, `cout` = 0; `busy` high for 9 cycles.
- WIDTH=8, `op_a` = 0xA5, `op_b` = 0x5A, `cin` = 1 -> `sum` = 0x00, `cout` = 1. Repeat with `op_a` = 0xFF, `op_b` = 0x01, `cin` = 0 -> `sum` = 0x00, `cout` = 1 (full carry propagation).
- Start 0x10 + 0x20, then pulse `start` and change operands to 0xFF/0xFF during RUN -> result is 0x30, `cout` = 0; only one `done` pulse is seen.
- `start` held high for 3 operations -> `done` pulses exactly 10 edges apart; `sum` stays stable between pulses.
- Assert `rst` asynchronously between clock edges at bit 4 of 0xFF + 0xFF -> `busy`, `done`, `sum`, `cout` drop to 0 immediately. After release, 0x01 + 0x01 gives `sum` = 0x02.
- WIDTH=2, all 32 combinations of `op_a`, `op_b`, `cin` -> each `{cout, sum}` equals the arithmetic sum; each takes 4 edges from acceptance to IDLE.
